sha_padder: RTL and testbench

//  Streaming SHA-256 message padder; producer side of the 512-bit padded-block interface consumed by the hash core.

---
 rtl/sha256_pkg.sv | 21 ++
 rtl/sha_pad_tail.sv | 40 ++++
 rtl/sha_padder.sv | 184 ++++++++++++++++++
 tb/tb_sha_padder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared constants for the SHA-256 message padder: block geometry, the padding
// marker byte, where the length field lives, and the padder FSM state codes.
// No ports (package).
// -----------------------------------------------------------------------------
package sha256_pkg;

    localparam int BLOCK_W     = 512;
    localparam int BLOCK_BYTES = BLOCK_W / 8;
    localparam int LEN_FIELD_W = 64;
    localparam int LEN_OFS     = 56;          // first byte of the length field
    localparam logic [7:0] PAD_BYTE = 8'h80;

    // Padder FSM state codes
    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] PAD  = 2'd1;
    localparam logic [1:0] TAIL = 2'd2;
    localparam logic [1:0] EMIT = 2'd3;

endpackage

// File: rtl/sha_pad_tail.sv
// -----------------------------------------------------------------------------
// sha_pad_tail
// Combinational block builder. Keeps buffer bytes 0..ptr-1, optionally places
// the 0x80 marker at byte ptr, zeroes everything else and optionally overlays
// the 64-bit big-endian bit length on bytes 56..63.
// Ports:
//   buffer     in  512  current block contents, byte 0 in [511:504]
//   ptr        in  7    number of valid message bytes in buffer (0..64)
//   len        in  64   message bit length (already zero-extended)
//   add_marker in  1    write 0x80 at byte ptr (ignored when ptr==64)
//   add_len    in  1    write len into bytes 56..63
//   block      out 512  resulting block
// -----------------------------------------------------------------------------
module sha_pad_tail
    import sha256_pkg::*;
(
    input  logic [BLOCK_W-1:0]     buffer,
    input  logic [6:0]             ptr,
    input  logic [LEN_FIELD_W-1:0] len,
    input  logic                   add_marker,
    input  logic                   add_len,
    output logic [BLOCK_W-1:0]     block
);

    always_comb begin
        block = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (7'(i) < ptr) begin
                block[BLOCK_W-1-8*i -: 8] = buffer[BLOCK_W-1-8*i -: 8];
            end else if ((7'(i) == ptr) && add_marker) begin
                block[BLOCK_W-1-8*i -: 8] = PAD_BYTE;
            end
        end
        // Bytes LEN_OFS..63 occupy the low 64 bits of the block.
        if (add_len) begin
            block[LEN_FIELD_W-1:0] = len;
        end
    end

endmodule

// File: rtl/sha_padder.sv
// -----------------------------------------------------------------------------
// sha_padder
// Streaming SHA-256 message padder. Packs message bytes big-endian into a
// single 512-bit buffer, appends 0x80, zero fill and the 64-bit bit length,
// and hands complete blocks to the hash core over a valid/ready handshake.
// Filling and emitting never overlap: the buffer doubles as the output
// register, so blk_data is stable for as long as blk_valid is high.
// Optional feature: define SHA_PADDER_LEN_CHECK_EN to flag (sticky err) and
// drop any byte that would wrap the LEN_W-bit length counter; otherwise err
// is tied low and the length wraps silently.
// Parameters:
//   LEN_W      width of the bit-length counter (8..64)
// Ports:
//   clk        in   1    clock
//   rst        in   1    asynchronous reset, active low
//   in_valid   in   1    byte strobe
//   in_ready   out  1    padder accepts a beat this cycle
//   in_data    in   8    message byte
//   in_keep    in   1    1: in_data is a message byte, 0: terminator only
//   in_last    in   1    final beat of the message
//   blk_valid  out  1    blk_data holds a complete block
//   blk_ready  in   1    consumer takes the block
//   blk_data   out  512  padded block, first byte in [511:504]
//   blk_last   out  1    block is the final block of the message
//   err        out  1    length overflow flag
// -----------------------------------------------------------------------------
module sha_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_keep,
    input  logic               in_last,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic [BLOCK_W-1:0] blk_data,
    output logic               blk_last,
    output logic               err
);

    logic [1:0]         state;
    logic [6:0]         ptr;
    logic [LEN_W-1:0]   len;
    logic               tail_pending;
    logic               marker_pending;   // 0x80 still owed to the tail block
    logic [BLOCK_W-1:0] data_buf;

    logic               accept;
    logic               len_wrap;
    logic               write_byte;
    logic [6:0]         ptr_next;
    logic [BLOCK_W-1:0] wr_lane;

    logic [6:0]         pt_ptr;
    logic               pt_marker;
    logic               pt_len;
    logic [BLOCK_W-1:0] padded;

    assign in_ready  = (state == FILL);
    assign blk_valid = (state == EMIT);
    assign blk_data  = data_buf;

    assign accept = in_valid & in_ready;

`ifdef SHA_PADDER_LEN_CHECK_EN
    // len + 8 would reach 2^LEN_W exactly when ~len < 8.
    assign len_wrap = (~len < LEN_W'(8));
`else
    assign len_wrap = 1'b0;
`endif

    assign write_byte = accept & in_keep & ~len_wrap;
    assign ptr_next   = ptr + 7'(write_byte);
    // The buffer is all-zero beyond ptr while filling, so a shifted OR places the byte.
    assign wr_lane    = {in_data, {(BLOCK_W-8){1'b0}}};

    // PAD finishes the current block; TAIL builds a fresh marker/length block.
    always_comb begin
        pt_ptr    = ptr;
        pt_marker = (ptr < 7'd64);
        pt_len    = (ptr <= 7'(LEN_OFS - 1));
        if (state == TAIL) begin
            pt_ptr    = '0;
            pt_marker = marker_pending;
            pt_len    = 1'b1;
        end
    end

    sha_pad_tail u_pad_tail (
        .buffer     (data_buf),
        .ptr        (pt_ptr),
        .len        (LEN_FIELD_W'(len)),
        .add_marker (pt_marker),
        .add_len    (pt_len),
        .block      (padded)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= FILL;
            ptr            <= '0;
            len            <= '0;
            tail_pending   <= 1'b0;
            marker_pending <= 1'b0;
            data_buf       <= '0;
            blk_last       <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        if (write_byte) begin
                            data_buf <= data_buf | (wr_lane >> {ptr, 3'b000});
                            ptr      <= ptr_next;
                            len      <= len + LEN_W'(8);
                        end
                        // A block filled by the last beat still goes through PAD.
                        if (in_last) begin
                            state <= PAD;
                        end else if (ptr_next == 7'd64) begin
                            state <= EMIT;
                        end
                    end
                end
                PAD: begin
                    data_buf <= padded;
                    state    <= EMIT;
                    if (ptr == 7'd64) begin
                        tail_pending   <= 1'b1;
                        marker_pending <= 1'b1;
                        blk_last       <= 1'b0;
                    end else if (ptr <= 7'(LEN_OFS - 1)) begin
                        tail_pending   <= 1'b0;
                        marker_pending <= 1'b0;
                        blk_last       <= 1'b1;
                    end else begin
                        tail_pending   <= 1'b1;
                        marker_pending <= 1'b0;
                        blk_last       <= 1'b0;
                    end
                end
                TAIL: begin
                    data_buf <= padded;
                    blk_last <= 1'b1;
                    state    <= EMIT;
                end
                EMIT: begin
                    if (blk_ready) begin
                        data_buf <= '0;
                        ptr      <= '0;
                        blk_last <= 1'b0;
                        if (tail_pending) begin
                            tail_pending <= 1'b0;
                            state        <= TAIL;
                        end else begin
                            state <= FILL;
                            if (blk_last) begin
                                len <= '0;
                            end
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef SHA_PADDER_LEN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (accept && in_keep && len_wrap) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sha_padder.sv
// -----------------------------------------------------------------------------
// tb_sha_padder
// Self-checking bench for sha_padder. Reference model is plain SHA-256 message
// padding over a byte queue. Two instances: LEN_W=64 for the main tests and
// LEN_W=8 for the length-wrap case; use8 steers the stimulus and outputs.
// -----------------------------------------------------------------------------
module tb_sha_padder;

    typedef logic [7:0] byte_q_t [$];
    typedef struct packed { logic [511:0] data; logic last; } blk_t;
    typedef blk_t blk_q_t [$];

    typedef struct {
        string   name;
        int      base;
        int      n;
        bit      term;
        int      rmode;
        int      exp_nblk;
        longint  exp_len;
        int      mark_blk;
        int      mark_pos;
    } vec_t;

`ifdef SHA_PADDER_LEN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_keep, in_last, blk_ready, use8;
    logic [7:0]   in_data;

    logic         r64, v64, l64, e64, r8, v8, l8, e8;
    logic [511:0] d64, d8;

    logic         in_ready_m, blk_valid_m, blk_last_m, err_m;
    logic [511:0] blk_data_m;

    assign in_ready_m  = use8 ? r8 : r64;
    assign blk_valid_m = use8 ? v8 : v64;
    assign blk_last_m  = use8 ? l8 : l64;
    assign blk_data_m  = use8 ? d8 : d64;
    assign err_m       = use8 ? e8 : e64;

    sha_padder #(.LEN_W(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid & ~use8), .in_ready(r64),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .blk_valid(v64), .blk_ready(blk_ready), .blk_data(d64),
        .blk_last(l64), .err(e64)
    );

    sha_padder #(.LEN_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid & use8), .in_ready(r8),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .blk_valid(v8), .blk_ready(blk_ready), .blk_data(d8),
        .blk_last(l8), .err(e8)
    );

    int     n_chk = 0;
    int     n_pass = 0;
    int     cyc = 0;
    int     ready_mode = 0;
    int     last_acc_cyc = 0;
    logic   prev_v = 1'b0;
    blk_q_t got;
    int     rise_q[$];
    int     hs_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       blk_ready = 1'b1;
            1:       blk_ready = 1'($urandom_range(0, 1));
            default: blk_ready = 1'b0;
        endcase
    end

    // Sampled mid-cycle; a handshake seen here completes on the next posedge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (blk_valid_m && !prev_v) rise_q.push_back(cyc);
            if (blk_valid_m && blk_ready) begin
                got.push_back({blk_data_m, blk_last_m});
                hs_q.push_back(cyc);
            end
            prev_v <= blk_valid_m;
        end else begin
            prev_v <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic void pad_model(input byte_q_t msg, input int len_w, input bit chk,
                                      output blk_q_t blks, output bit err_o);
        byte_q_t p;
        longint unsigned cnt = 0;
        longint unsigned bitlen;
        int nb;
        err_o = 1'b0;
        blks  = {};
        foreach (msg[i]) begin
            if (chk && len_w < 64 && ((cnt + 1) * 8 >= (64'd1 << len_w))) err_o = 1'b1;
            else begin
                p.push_back(msg[i]);
                cnt++;
            end
        end
        bitlen = cnt * 8;
        if (len_w < 64) bitlen = bitlen % (64'd1 << len_w);
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(8'(bitlen >> (8 * k)));
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            blk_t t;
            t.data = '0;
            for (int j = 0; j < 64; j++) t.data[511 - 8*j -: 8] = p[b*64 + j];
            t.last = (b == nb - 1);
            blks.push_back(t);
        end
    endfunction

    task automatic drive_beat(input logic [7:0] d, input logic k, input logic l);
        int t = 0;
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        while (!ok && t < 300) begin
            @(negedge clk);
            ok = in_ready_m;
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL beat_timeout: in_ready stayed %0b for %0d cycles", in_ready_m, t);
        end
        last_acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_msg(input byte_q_t msg, input bit term_only, input bit gaps,
                            input bit skips, input bit no_last);
        int n = msg.size();
        bit term = term_only || (n == 0);
        for (int i = 0; i < n; i++) begin
            if (skips && $urandom_range(0, 3) == 0) drive_beat(8'($urandom), 1'b0, 1'b0);
            drive_beat(msg[i], 1'b1, (i == n - 1) && !term && !no_last);
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        if (term && !no_last) drive_beat(8'($urandom), 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic wait_blocks(input int exp_n);
        int t = 0;
        while (got.size() < exp_n && t < 2000) begin @(posedge clk); #1; t++; end
        repeat (6) begin @(posedge clk); #1; end
    endtask

    task automatic compare_blocks(input string name, input blk_q_t exp);
        check($sformatf("%s_nblk", name), got.size(), exp.size());
        for (int b = 0; b < exp.size(); b++) begin
            blk_t g = (b < got.size()) ? got[b] : '0;
            check($sformatf("%s_blk%0d", name, b), {g.data, g.last}, {exp[b].data, exp[b].last});
        end
    endtask

    task automatic run_and_compare(input string name, input byte_q_t msg, input bit term_only,
                                   input bit gaps, input bit skips, input int len_w,
                                   output blk_q_t exp, output bit exp_err);
        got = {}; rise_q = {}; hs_q = {};
        pad_model(msg, len_w, CHK_EN, exp, exp_err);
        send_msg(msg, term_only, gaps, skips, 1'b0);
        wait_blocks(exp.size());
        compare_blocks(name, exp);
    endtask

    function automatic blk_t get_blk(input int idx);
        return (idx < got.size()) ? got[idx] : '0;
    endfunction

    localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};

    vec_t    tbl[8];
    byte_q_t msg;
    blk_q_t  exp;
    bit      exp_err;
    blk_t    b;
    logic [511:0] d0;
    bit      stable;
    int      t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{"abc",   'h61,   3, 1'b0, 0, 1,   24, 0,  3};
        tbl[1] = '{"empty", 0,      0, 1'b1, 0, 1,    0, 0,  0};
        tbl[2] = '{"b55",   0,     55, 1'b0, 1, 1,  440, 0, 55};
        tbl[3] = '{"b56",   0,     56, 1'b0, 1, 2,  448, 0, 56};
        tbl[4] = '{"b63",   'h10,  63, 1'b1, 1, 2,  504, 0, 63};
        tbl[5] = '{"b64",   'h20,  64, 1'b0, 0, 2,  512, 1,  0};
        tbl[6] = '{"b65",   'h30,  65, 1'b0, 1, 2,  520, 1,  1};
        tbl[7] = '{"b128",  'h40, 128, 1'b1, 1, 3, 1024, 2,  0};

        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_keep = 1'b0; in_last = 1'b0;
        blk_ready = 1'b1; use8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_blk_valid", blk_valid_m, 1'b0);
        check("rst_blk_data",  blk_data_m,  '0);
        check("rst_blk_last",  blk_last_m,  1'b0);
        check("rst_err",       err_m,       1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready_m, 1'b1);

        // Table-driven messages
        for (int i = 0; i < 8; i++) begin
            msg = {};
            for (int j = 0; j < tbl[i].n; j++) msg.push_back(8'(tbl[i].base + j));
            ready_mode = tbl[i].rmode;
            run_and_compare(tbl[i].name, msg, tbl[i].term, 1'b0, 1'b0, 64, exp, exp_err);
            b = get_blk(tbl[i].exp_nblk - 1);
            check({tbl[i].name, "_lenfield"}, b.data[63:0], tbl[i].exp_len);
            b = get_blk(tbl[i].mark_blk);
            check({tbl[i].name, "_marker"}, b.data[511 - 8*tbl[i].mark_pos -: 8], 8'h80);
            if (i == 0) begin
                check("abc_block", {get_blk(0).data, get_blk(0).last}, {ABC_BLK, 1'b1});
                // One counter step between accept edge and first valid sample = valid in cycle N+2.
                check("abc_latency", (rise_q.size() > 0) ? rise_q[0] - last_acc_cyc : -1, 1);
            end
        end

        // 64 bytes with the consumer stalled for 10 cycles
        ready_mode = 2;
        msg = {};
        for (int j = 0; j < 64; j++) msg.push_back(8'(j));
        got = {}; rise_q = {}; hs_q = {};
        pad_model(msg, 64, CHK_EN, exp, exp_err);
        send_msg(msg, 1'b0, 1'b0, 1'b0, 1'b0);
        t = 0;
        while (!blk_valid_m && t < 50) begin @(posedge clk); #1; t++; end
        @(negedge clk);
        d0 = blk_data_m;
        stable = blk_valid_m;
        repeat (10) begin
            @(negedge clk);
            if (in_ready_m || !blk_valid_m || blk_data_m !== d0) stable = 1'b0;
        end
        check("stall_hold", stable, 1'b1);
        check("stall_data", d0, exp[0].data);
        ready_mode = 0;
        wait_blocks(2);
        compare_blocks("stall64", exp);
        b = get_blk(1);
        check("stall64_tail", {b.data, b.last}, {8'h80, 440'h0, 64'h200, 1'b1});
        check("tail_latency", (rise_q.size() > 1 && hs_q.size() > 0) ? rise_q[1] - hs_q[0] : -1, 2);

        // Reset in the middle of a message, then "abc"
        msg = {};
        for (int j = 0; j < 20; j++) msg.push_back(8'(8'hc0 + j));
        send_msg(msg, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready",  in_ready_m,  1'b1);
        check("midrst_blk_valid", blk_valid_m, 1'b0);
        check("midrst_blk_data",  blk_data_m,  '0);
        check("midrst_blk_last",  blk_last_m,  1'b0);
        @(posedge clk); #1;
        msg = '{8'h61, 8'h62, 8'h63};
        run_and_compare("abc_after_rst", msg, 1'b0, 1'b0, 1'b0, 64, exp, exp_err);
        check("abc_after_rst_const", {get_blk(0).data, get_blk(0).last}, {ABC_BLK, 1'b1});

        // 32 bytes into the LEN_W=8 instance: the 32nd byte wraps the length
        use8 = 1'b1;
        @(posedge clk); #1;
        msg = {};
        for (int j = 0; j < 32; j++) msg.push_back(8'(8'ha0 + j));
        run_and_compare("len8_wrap", msg, 1'b0, 1'b0, 1'b0, 8, exp, exp_err);
        check("len8_err", err_m, exp_err);
        use8 = 1'b0;
        @(posedge clk); #1;

        // Randomised messages with gaps, ignored beats and consumer stalls
        ready_mode = 1;
        for (int r = 0; r < 25; r++) begin
            int n = $urandom_range(0, 140);
            msg = {};
            for (int j = 0; j < n; j++) msg.push_back(8'($urandom));
            run_and_compare($sformatf("rnd%0d_n%0d", r, n), msg, 1'($urandom_range(0, 1)),
                            1'b1, 1'b1, 64, exp, exp_err);
        end
        ready_mode = 0;
        check("rnd_err_clear", err_m, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
